// File: rtl/axi_mem_slave_pkg.sv
// axi_mem_slave_pkg: burst/response codes, channel FSM states and burst helpers
package axi_mem_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} rstate_t;

    // WRAP and the reserved encoding are not supported and flag the burst
    function automatic logic burst_err(input logic [1:0] b);
        return (b == BURST_WRAP) || (b == 2'b11);
    endfunction

    // unsupported types still walk the address as INCR
    function automatic logic burst_steps(input logic [1:0] b);
        return (b == BURST_INCR) || burst_err(b);
    endfunction

endpackage

// File: rtl/axi_mem_slave_ram.sv
// axi_mem_ram: simple dual-port word RAM, byte-enabled write, registered read-first read
// ports: clk_i, rst_i (async, read register only), we_i/be_i/waddr_i/wdata_i write port,
//        re_i/raddr_i read request, rdata_o registered read data
module axi_mem_ram #(
    parameter int AW = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] ram_array [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++)
            if (we_i && be_i[b]) ram_array[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end

    // separate process from the write: a same-edge collision sees the old word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_o <= '0;
        else if (re_i) rdata_o <= ram_array[raddr_i];
    end

endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 slave backed by a word-addressed 32-bit RAM, INCR/FIXED bursts
// ports: CLK, RST (async active-high); AW/W/B write channels; AR/R read channels.
//        Address bits above the RAM depth and addr[1:0] are ignored (aliasing).
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_ID_WIDTH   = 1,
    parameter int C_MEM_WORDS_LOG2 = 11
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                  S_AXI_AWLEN,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]                  S_AXI_WSTRB,
    input  logic                        S_AXI_WLAST,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_BID,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [C_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                  S_AXI_ARLEN,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [C_AXI_ID_WIDTH-1:0]   S_AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RLAST,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY
);

    localparam int LG = C_MEM_WORDS_LOG2;

    wstate_t                   w_state_q;
    logic [C_AXI_ID_WIDTH-1:0] awid_q;
    logic [LG-1:0]             waddr_q;
    logic [7:0]                wcnt_q;
    logic                      wstep_q, werr_q;
    logic                      awready_q, wready_q, bvalid_q;
    logic [1:0]                bresp_q;

    rstate_t                   r_state_q;
    logic [C_AXI_ID_WIDTH-1:0] arid_q;
    logic [LG-1:0]             raddr_q;
    logic [7:0]                rcnt_q;
    logic                      rstep_q;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [1:0]                rresp_q;

    logic                      unused_addr;

    assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = awid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RID     = arid_q;

    axi_mem_ram #(.AW(LG)) u_ram (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (wready_q && S_AXI_WVALID),
        .be_i    (S_AXI_WSTRB),
        .waddr_i (waddr_q),
        .wdata_i (S_AXI_WDATA),
        .re_i    (r_state_q == R_READ),
        .raddr_i (raddr_q),
        .rdata_o (S_AXI_RDATA)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state_q <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            wcnt_q    <= '0;
            wstep_q   <= 1'b0;
            werr_q    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: if (S_AXI_AWVALID) begin
                    awid_q    <= S_AXI_AWID;
                    waddr_q   <= S_AXI_AWADDR[LG+1:2];
                    wcnt_q    <= S_AXI_AWLEN;
                    wstep_q   <= burst_steps(S_AXI_AWBURST);
                    werr_q    <= burst_err(S_AXI_AWBURST);
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (S_AXI_WVALID) begin
                    waddr_q <= waddr_q + LG'(wstep_q);
                    wcnt_q  <= wcnt_q - 8'd1;
                    // WLAST must coincide with the final beat; early WLAST is only an error
                    if (S_AXI_WLAST != (wcnt_q == 8'd0)) werr_q <= 1'b1;
                    if (wcnt_q == 8'd0) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= (werr_q || !S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (S_AXI_BREADY) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rstep_q   <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: if (S_AXI_ARVALID) begin
                    arid_q    <= S_AXI_ARID;
                    raddr_q   <= S_AXI_ARADDR[LG+1:2];
                    rcnt_q    <= S_AXI_ARLEN;
                    rstep_q   <= burst_steps(S_AXI_ARBURST);
                    rresp_q   <= burst_err(S_AXI_ARBURST) ? RESP_SLVERR : RESP_OKAY;
                    arready_q <= 1'b0;
                    r_state_q <= R_READ;
                end
                // the RAM captures raddr_q on this edge; data is valid in R_DATA
                R_READ: begin
                    rvalid_q  <= 1'b1;
                    rlast_q   <= (rcnt_q == 8'd0);
                    r_state_q <= R_DATA;
                end
                R_DATA: if (S_AXI_RREADY) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    if (rlast_q) begin
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end else begin
                        raddr_q   <= raddr_q + LG'(rstep_q);
                        rcnt_q    <= rcnt_q - 8'd1;
                        r_state_q <= R_READ;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed bench with a word-array memory model and an R-channel scoreboard
module tb_axi_mem_slave;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [0:0]  S_AXI_AWID = '0;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0;
    logic [1:0]  S_AXI_AWBURST = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WLAST = 1'b0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [0:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [0:0]  S_AXI_ARID = '0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_ARLEN = '0;
    logic [1:0]  S_AXI_ARBURST = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [0:0]  S_AXI_RID;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    always #5 CLK = ~CLK;

    axi_mem_slave dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } rexp_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem [0:2047];
    rexp_t       exp_q[$];
    logic [31:0] last_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[12:2]);
    endfunction

    // every cycle R carries data it must match the head of the expected-beat queue
    always @(negedge CLK) begin
        if (!RST && S_AXI_RVALID) begin
            if (exp_q.size() == 0) chk("r_unexpected_beat", {31'd0, S_AXI_RVALID}, 32'd0);
            else begin
                chk("rdata", S_AXI_RDATA, exp_q[0].d);
                chk("rresp", {30'd0, S_AXI_RRESP}, {30'd0, exp_q[0].resp});
                chk("rlast", {31'd0, S_AXI_RLAST}, {31'd0, exp_q[0].last});
                chk("rid", {31'd0, S_AXI_RID}, {31'd0, exp_q[0].id});
                if (S_AXI_RREADY) begin
                    last_rdata = S_AXI_RDATA;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // abort_at >= 0 asserts RST at the start of that beat instead of sending it
    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [31:0] base, input logic [3:0] strb, input int last_at,
                            input logic id, input int abort_at);
        int t;
        logic [31:0] a, d;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len);
        S_AXI_AWBURST = burst; S_AXI_AWVALID = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!S_AXI_AWREADY && t < 50) begin @(negedge CLK); t++; end
        chk("aw_wait", {31'd0, t < 50}, 32'd1);
        @(posedge CLK); #1;
        S_AXI_AWVALID = 1'b0;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) begin
                S_AXI_WVALID = 1'b0;
                RST = 1'b1;
                #1;
                chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
                chk("rst_wready", {31'd0, S_AXI_WREADY}, 32'd0);
                chk("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
                @(posedge CLK); #1;
                RST = 1'b0;
                return;
            end
            d = base + 32'(i);
            S_AXI_WDATA = d; S_AXI_WSTRB = strb; S_AXI_WLAST = (i == last_at); S_AXI_WVALID = 1'b1;
            t = 0;
            @(negedge CLK);
            while (!S_AXI_WREADY && t < 50) begin @(negedge CLK); t++; end
            chk("w_wait", {31'd0, t < 50}, 32'd1);
            @(posedge CLK);
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[widx(a)][8*b +: 8] = d[8*b +: 8];
            a = (burst == 2'b00) ? a : a + 32'd4;
            #1;
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        S_AXI_BREADY = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!S_AXI_BVALID && t < 50) begin @(negedge CLK); t++; end
        chk("b_wait", {31'd0, t < 50}, 32'd1);
        chk("bresp", {30'd0, S_AXI_BRESP}, (burst >= 2'b10 || last_at != len) ? 32'd2 : 32'd0);
        chk("bid", {31'd0, S_AXI_BID}, {31'd0, id});
        @(posedge CLK); #1;
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic id, input bit toggle);
        int t;
        bit tog;
        logic [31:0] a;
        rexp_t e;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            e.d = mem[widx(a)];
            e.resp = (burst >= 2'b10) ? 2'b10 : 2'b00;
            e.last = (i == len);
            e.id = id;
            exp_q.push_back(e);
            a = (burst == 2'b00) ? a : a + 32'd4;
        end
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len);
        S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!S_AXI_ARREADY && t < 50) begin @(negedge CLK); t++; end
        chk("ar_wait", {31'd0, t < 50}, 32'd1);
        @(posedge CLK); #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge CLK);
        chk("r_latency_c1", {31'd0, S_AXI_RVALID}, 32'd0);
        @(negedge CLK);
        chk("r_latency_c2", {31'd0, S_AXI_RVALID}, 32'd1);
        @(posedge CLK); #1;
        tog = 1'b1;
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            S_AXI_RREADY = toggle ? tog : 1'b1;
            @(posedge CLK); #1;
            tog = !tog;
            t++;
        end
        S_AXI_RREADY = 1'b0;
        chk("r_drain", {31'd0, t < 100}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("reset_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        chk("reset_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        chk("reset_wready", {31'd0, S_AXI_WREADY}, 32'd0);
        chk("reset_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        chk("reset_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("reset_rlast", {31'd0, S_AXI_RLAST}, 32'd0);
        chk("reset_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        chk("reset_rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        chk("reset_rdata", S_AXI_RDATA, 32'd0);
        chk("reset_ids", {30'd0, S_AXI_BID, S_AXI_RID}, 32'd0);
        @(posedge CLK); #1;

        do_write(32'h10, 0, 2'b01, 32'hDEADBEEF, 4'hF, 0, 1'b1, -1);
        do_read(32'h10, 0, 2'b01, 1'b1, 1'b0);
        chk("t1_literal", last_rdata, 32'hDEADBEEF);
        do_read(32'h2010, 0, 2'b01, 1'b0, 1'b0);
        chk("alias_literal", last_rdata, 32'hDEADBEEF);

        do_write(32'h100, 3, 2'b01, 32'd1, 4'hF, 3, 1'b0, -1);
        do_read(32'h100, 3, 2'b01, 1'b0, 1'b1);
        chk("t2_literal", last_rdata, 32'd4);

        do_write(32'h20, 0, 2'b01, 32'h11223344, 4'hF, 0, 1'b0, -1);
        do_write(32'h20, 0, 2'b01, 32'hAABBCCDD, 4'h5, 0, 1'b1, -1);
        chk("t3_model", mem[8], 32'h11BB33DD);
        do_read(32'h20, 2, 2'b00, 1'b1, 1'b0);
        chk("t3_literal", last_rdata, 32'h11BB33DD);

        do_write(32'h300, 3, 2'b01, 32'h30, 4'hF, 1, 1'b0, -1);
        do_read(32'h300, 3, 2'b10, 1'b0, 1'b0);
        chk("t4_literal", last_rdata, 32'h33);

        do_write(32'h1C, 0, 2'b01, 32'h0, 4'hF, 0, 1'b0, -1);
        fork
            do_write(32'h1C, 0, 2'b01, 32'h55, 4'hF, 0, 1'b1, -1);
            do_read(32'h1C, 0, 2'b01, 1'b1, 1'b0);
        join
        chk("t5_collision_old", last_rdata, 32'h0);
        do_read(32'h1C, 0, 2'b01, 1'b0, 1'b0);
        chk("t5_after_new", last_rdata, 32'h55);

        do_write(32'h200, 3, 2'b01, 32'hA0, 4'hF, 3, 1'b0, 2);
        do_read(32'h200, 1, 2'b01, 1'b0, 1'b0);
        chk("t6_retained", last_rdata, 32'hA1);
        do_write(32'h200, 3, 2'b01, 32'hB0, 4'hF, 3, 1'b1, -1);
        do_read(32'h200, 3, 2'b01, 1'b1, 1'b1);
        chk("t6_new_burst", last_rdata, 32'hB3);

        repeat (2) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
